regfile: RTL and testbench

//  General-purpose register file at the far end of the write-back path.

---
 rtl/regfile.sv | 112 +++++++++++
 tb/tb_regfile.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Two-read, one-write register file with a post-reset clear sequencer.
// Entry 0 always reads as zero; same-cycle writes bypass to the read ports.
module regfile #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  output logic          ready
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          ready_q, ready_d;

  logic [DW-1:0] mem_q [NREG];

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= AW'(1);
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    wr_en     = 1'b0;
    wr_addr   = waddr;
    wr_data   = wdata;
    unique case (state_q)
      CLEAR: begin
        // Single write port shared with the sequencer keeps RAM inference
        wr_en     = 1'b1;
        wr_addr   = clr_ptr_q;
        wr_data   = '0;
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        wr_en = we && (waddr != '0);
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
    if (rst) begin
      wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (rst || !ready_q || !re1 || raddr1 == '0) begin
      rdata1 = '0;
    end else if (we && waddr == raddr1) begin
      rdata1 = wdata;
    end else begin
      rdata1 = mem_q[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst || !ready_q || !re2 || raddr2 == '0) begin
      rdata2 = '0;
    end else if (we && waddr == raddr2) begin
      rdata2 = wdata;
    end else begin
      rdata2 = mem_q[raddr2];
    end
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile.sv
// Directed and pseudo-random checks of regfile with a scoreboard queue.
// Expected values come from a reference model kept in the bench.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        ready;

  regfile #(.DW(32), .AW(5), .NREG(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re1   (re1),
    .raddr1(raddr1),
    .rdata1(rdata1),
    .re2   (re2),
    .raddr2(raddr2),
    .rdata2(rdata2),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } item_t;

  item_t       sb[$];
  int          checks;
  int          failures;
  logic [31:0] model [32];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int sig,
                      input logic [31:0] exp);
    item_t it;
    it.tag = tag;
    it.sig = sig;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic check_all();
    item_t       it;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.sig)
        0:       obs = rdata1;
        1:       obs = rdata2;
        default: obs = {31'd0, ready};
      endcase
      checks++;
      assert (obs === it.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0;
    re2 = 1'b0; raddr2 = '0;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 1; i <= 31; i++) begin
      step();
      push(tag, 2, {31'd0, (i == 31)});
      push({tag, "_rd1"}, 0, 32'd0);
      push({tag, "_rd2"}, 1, 32'd0);
      check_all();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    idle();
    rst = 1'b1;
    re1 = 1'b1; raddr1 = 5'd1;
    re2 = 1'b1; raddr2 = 5'd2;
    step();
    push("rst_ready", 2, 32'd0);
    push("rst_rd1", 0, 32'd0);
    push("rst_rd2", 1, 32'd0);
    check_all();
    step();
    rst = 1'b0;

    for (int i = 1; i <= 31; i++) begin
      if (i == 5) begin
        we = 1'b1; waddr = 5'd3; wdata = 32'hAA;
      end else begin
        we = 1'b0;
      end
      step();
      push("clr_ready", 2, {31'd0, (i == 31)});
      if (i < 31) push("clr_rd1", 0, 32'd0);
      check_all();
    end
    idle();

    for (int a = 0; a < 32; a++) begin
      re1 = 1'b1; raddr1 = 5'(a);
      re2 = 1'b1; raddr2 = 5'(31 - a);
      push("zero_rd1", 0, 32'd0);
      push("zero_rd2", 1, 32'd0);
      check_all();
    end
    idle();

    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    model[5] = 32'hDEADBEEF;
    we = 1'b0;
    re1 = 1'b1; raddr1 = 5'd5;
    push("wr_rd", 0, 32'hDEADBEEF);
    check_all();
    re1 = 1'b0;
    push("re1_off", 0, 32'd0);
    check_all();

    we = 1'b1; waddr = 5'd7; wdata = 32'h1234;
    re2 = 1'b1; raddr2 = 5'd7;
    re1 = 1'b1; raddr1 = 5'd7;
    push("byp_rd2", 1, 32'h1234);
    push("byp_rd1", 0, 32'h1234);
    check_all();
    step();
    model[7] = 32'h1234;
    we = 1'b0;
    push("byp_hold", 1, 32'h1234);
    check_all();

    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    re1 = 1'b1; raddr1 = 5'd0;
    push("r0_same", 0, 32'd0);
    check_all();
    step();
    we = 1'b0;
    push("r0_next", 0, 32'd0);
    check_all();

    we = 1'b1; waddr = 5'd12; wdata = 32'h11111111;
    re1 = 1'b1; raddr1 = 5'd12;
    push("b2b_a", 0, 32'h11111111);
    check_all();
    step();
    wdata = 32'h80000001;
    push("b2b_b", 0, 32'h80000001);
    check_all();
    step();
    model[12] = 32'h80000001;
    we = 1'b0;
    push("b2b_last", 0, 32'h80000001);
    check_all();

    for (int n = 0; n < 40; n++) begin
      logic [31:0] e1;
      logic [31:0] e2;
      we = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom;
      re1 = 1'($urandom_range(0, 3) != 0);
      raddr1 = (n % 4 == 0) ? waddr : 5'($urandom_range(0, 31));
      re2 = 1'($urandom_range(0, 3) != 0);
      raddr2 = 5'($urandom_range(0, 31));
      e1 = !re1 || raddr1 == 0 ? 32'd0 :
           (we && waddr == raddr1) ? wdata : model[raddr1];
      e2 = !re2 || raddr2 == 0 ? 32'd0 :
           (we && waddr == raddr2) ? wdata : model[raddr2];
      push("rand_rd1", 0, e1);
      push("rand_rd2", 1, e2);
      check_all();
      step();
      if (we && waddr != 0) model[waddr] = wdata;
    end
    idle();

    we = 1'b1; waddr = 5'd9; wdata = 32'h55;
    step();
    we = 1'b0;
    re1 = 1'b1; raddr1 = 5'd9;
    push("r9_run", 0, 32'h55);
    check_all();
    rst = 1'b1;
    push("r9_in_rst", 0, 32'd0);
    check_all();
    step();
    rst = 1'b0;
    push("mid_rst_ready", 2, 32'd0);
    check_all();
    wait_ready("mid_rst");
    re1 = 1'b1; raddr1 = 5'd9;
    re2 = 1'b1; raddr2 = 5'd5;
    push("r9_cleared", 0, 32'd0);
    push("r5_cleared", 1, 32'd0);
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
